rbz_spi_cmd_arbiter: RTL
========================

// Module: rbz_spi_cmd_arbiter
// PURPOSE
//  Shares rbzero's two SPI slave ports (vector, register) between two command requesters:
//  req0 = host/LA path, req1 = on-chip demo/auto-update generator.
//  Arbitrates, then serialises a parallel word MSB-first onto the chosen port's csb/sclk/mosi.
//  Outputs feed the rbzero i_ss_n/i_sclk/i_mosi and i_reg_ss_n/i_reg_sclk/i_reg_mosi ports.
// PARAMETERS
//  DATA_W    64  max payload bits per command
//  LEN_W      7  width of length fields; must satisfy 2**LEN_W > DATA_W
//  HALF_DIV   2  i_clk cycles per SCLK half-period; >=1
//  GAP_CYC    4  i_clk cycles csb held high between commands; >=1
// PORTS
//  i_clk          in   1       clock
//  i_reset_n      in   1       async active-low reset
//  i_req0_valid   in   1       req0 command pending; hold with fields stable until ack
//  i_req0_target  in   1       0 = vector port, 1 = register port
//  i_req0_len     in   LEN_W   bit count
//  i_req0_data    in   DATA_W  right-justified payload; bit len-1 sent first
//  o_req0_ack     out  1       1-cycle pulse: command latched
//  i_req1_*/o_req1_ack          identical set for req1
//  o_vec_csb/o_vec_sclk/o_vec_mosi  out  1 each  SPI master to vector slave
//  o_reg_csb/o_reg_sclk/o_reg_mosi  out  1 each  SPI master to register slave
//  o_busy         out  1       state != IDLE
//  o_grant        out  1       requester owning current/last command
// BEHAVIOUR
//  - One clock, i_clk. Reset is asynchronous, active-low (i_reset_n).
//  - Reset values: both csb=1, both sclk=0, both mosi=0, acks=0, o_busy=0,
//    o_grant=0, state=IDLE. Internal last_grant resets to 1 so req0 wins first.
//  - FSM states: IDLE, LOW, HIGH, GAP.
//  - IDLE, valid seen at edge t: grant is chosen.
//    At t+1: ack pulses, shift register and bit counter load, selected csb=0,
//    mosi=first bit, state LOW. o_busy=1.
//  - LOW: sclk=0 for HALF_DIV cycles, mosi stable; then HIGH.
//  - HIGH: sclk=1 for HALF_DIV cycles; the slave samples on the rising edge.
//    At end of HIGH: if bits remain, shift and go to LOW; else go to GAP.
//  - csb-low duration = 2*HALF_DIV*len cycles exactly.
//  - GAP: csb=1, sclk=0, mosi=0 for GAP_CYC cycles; then IDLE. A new grant is possible on the last GAP-to-IDLE edge+1.
//  - Non-selected port always idle (csb=1, sclk=0, mosi=0). Never both csb low.
//  - Round-robin: both valid in IDLE -> grant the one not equal last_grant.
//    Single valid -> grant it. last_grant updates on grant.
//  - len=0: ack pulses, no csb activity, straight to GAP.
//  - len>DATA_W: clamp to DATA_W.
//  - valid dropped before ack: request withdrawn; requests are only sampled in IDLE.
//  - Valid held after ack: treated as a new command (requester must drop valid in the ack cycle).
//  - Reset mid-transfer: csb forced high immediately (async). The partial frame is discarded (slave sees csb rise). No ack.
//  - Bit counter width LEN_W; no wrap, because the load value is <= DATA_W.
// CONFIGURATION
//  RBZ_ARB_FIXED_PRIO_EN defined: req0 has strict priority whenever both are valid. last_grant is ignored, and req1 may starve.
//  Undefined (default): round-robin as above.
// TESTING
//  1. Assert i_reset_n=0 mid-clock -> all csb=1, sclk=0, mosi=0, ack=0, busy=0 with no clock edge.
//  2. req0 target=0 len=8 data=0xA5, HALF_DIV=2 -> ack at t+1.
//     vec_csb low 32 cycles; 8 sclk rises sample 1,0,1,0,0,1,0,1. reg_* static.
//  3. After reset, both valid same cycle (req0 vec, req1 reg) -> req0 served first, req1 after GAP_CYC.
//     With both held continuously, the grant sequence is 0,1,0,1.
//  4. req1 len=0 -> single ack, no csb edge, busy for GAP_CYC+1.
//     len=100 -> exactly 64 sclk rises.
//  5. Reset pulse during bit 3 of a len=16 command -> csb high asynchronously, no ack.
//     The reissued command then completes with a correct bitstream.
//  6. With RBZ_ARB_FIXED_PRIO_EN, both valid held for 4 commands -> o_grant=0 every time and o_req1_ack never pulses.

Source files
------------

// File: rtl/rbz_spi_cmd_arbiter.sv
// Arbitrates two command requesters onto rbzero's vector/register SPI slave ports and serialises MSB-first.
// Define RBZ_ARB_FIXED_PRIO_EN for strict req0 priority; default build is round-robin.
module rbz_spi_cmd_arbiter #(
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 7,
  parameter int HALF_DIV = 2,
  parameter int GAP_CYC  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req0_valid,
  input  logic              i_req0_target,
  input  logic [LEN_W-1:0]  i_req0_len,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ack,
  input  logic              i_req1_valid,
  input  logic              i_req1_target,
  input  logic [LEN_W-1:0]  i_req1_len,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ack,
  output logic              o_vec_csb,
  output logic              o_vec_sclk,
  output logic              o_vec_mosi,
  output logic              o_reg_csb,
  output logic              o_reg_sclk,
  output logic              o_reg_mosi,
  output logic              o_busy,
  output logic              o_grant
);
  localparam int TMAX = (HALF_DIV > GAP_CYC + 1) ? HALF_DIV : GAP_CYC + 1;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [LEN_W-1:0]  bits_q, bits_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tgt_q, tgt_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              vec_csb_q, vec_csb_d, vec_sclk_q, vec_sclk_d, vec_mosi_q, vec_mosi_d;
  logic              reg_csb_q, reg_csb_d, reg_sclk_q, reg_sclk_d, reg_mosi_q, reg_mosi_d;
  logic              csb_low_d, sclk_d, mosi_d;
  logic              any_req, gnt, sel_tgt;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(DATA_W)) return LEN_W'(DATA_W);
    return len;
  endfunction

  // Right-justified payload moved so that bit len-1 sits in the MSB.
  function automatic logic [DATA_W-1:0] msb_align(input logic [DATA_W-1:0] data,
                                                  input logic [LEN_W-1:0]  len);
    return data << (DATA_W - int'(len));
  endfunction

  always_comb begin
    any_req = i_req0_valid | i_req1_valid;
`ifdef RBZ_ARB_FIXED_PRIO_EN
    gnt = ~i_req0_valid;
`else
    gnt = (i_req0_valid & i_req1_valid) ? ~last_grant_q : i_req1_valid;
`endif
    sel_tgt  = gnt ? i_req1_target : i_req0_target;
    sel_len  = clamp_len(gnt ? i_req1_len : i_req0_len);
    sel_data = gnt ? i_req1_data : i_req0_data;
  end

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    bits_d       = bits_q;
    shreg_d      = shreg_q;
    tgt_d        = tgt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    csb_low_d    = 1'b0;
    sclk_d       = 1'b0;
    mosi_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = gnt;
          last_grant_d = gnt;
          tgt_d        = sel_tgt;
          ack0_d       = ~gnt;
          ack1_d       = gnt;
          if (sel_len == '0) begin
            // Empty command: the ack cycle plus GAP_CYC idle cycles.
            state_d = GAP;
            tmr_d   = TW'(GAP_CYC);
          end else begin
            state_d   = LOW;
            tmr_d     = TW'(HALF_DIV - 1);
            bits_d    = sel_len;
            shreg_d   = msb_align(sel_data, sel_len);
            csb_low_d = 1'b1;
            mosi_d    = shreg_d[DATA_W-1];
          end
        end
      end
      LOW: begin
        csb_low_d = 1'b1;
        mosi_d    = shreg_q[DATA_W-1];
        if (tmr_q == '0) begin
          state_d = HIGH;
          tmr_d   = TW'(HALF_DIV - 1);
          sclk_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      HIGH: begin
        if (tmr_q != '0) begin
          csb_low_d = 1'b1;
          sclk_d    = 1'b1;
          mosi_d    = shreg_q[DATA_W-1];
          tmr_d     = tmr_q - 1'b1;
        end else if (bits_q > LEN_W'(1)) begin
          csb_low_d = 1'b1;
          mosi_d    = shreg_q[DATA_W-2];
          shreg_d   = shreg_q << 1;
          bits_d    = bits_q - 1'b1;
          state_d   = LOW;
          tmr_d     = TW'(HALF_DIV - 1);
        end else begin
          state_d = GAP;
          tmr_d   = TW'(GAP_CYC - 1);
        end
      end
      GAP: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    vec_csb_d  = ~(csb_low_d & ~tgt_d);
    vec_sclk_d = sclk_d & ~tgt_d;
    vec_mosi_d = mosi_d & ~tgt_d;
    reg_csb_d  = ~(csb_low_d & tgt_d);
    reg_sclk_d = sclk_d & tgt_d;
    reg_mosi_d = mosi_d & tgt_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      bits_q       <= '0;
      tgt_q        <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      vec_csb_q    <= 1'b1;
      vec_sclk_q   <= 1'b0;
      vec_mosi_q   <= 1'b0;
      reg_csb_q    <= 1'b1;
      reg_sclk_q   <= 1'b0;
      reg_mosi_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      bits_q       <= bits_d;
      tgt_q        <= tgt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      vec_csb_q    <= vec_csb_d;
      vec_sclk_q   <= vec_sclk_d;
      vec_mosi_q   <= vec_mosi_d;
      reg_csb_q    <= reg_csb_d;
      reg_sclk_q   <= reg_sclk_d;
      reg_mosi_q   <= reg_mosi_d;
    end
  end

  // Payload shift register is pure data and is always reloaded before use.
  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
  end

  assign o_req0_ack = ack0_q;
  assign o_req1_ack = ack1_q;
  assign o_vec_csb  = vec_csb_q;
  assign o_vec_sclk = vec_sclk_q;
  assign o_vec_mosi = vec_mosi_q;
  assign o_reg_csb  = reg_csb_q;
  assign o_reg_sclk = reg_sclk_q;
  assign o_reg_mosi = reg_mosi_q;
  assign o_busy     = (state_q != IDLE);
  assign o_grant    = grant_q;
endmodule
